// File: rtl/acc_scoreboard_if.sv
// acc_scoreboard_if: the word stream and DUT result signals
// observed by the accumulator scoreboard.
interface acc_scoreboard_if #(
    parameter int CHANNELS         = 3,
    parameter int PIXEL_WIDTH      = 8,
    parameter int WEIGHT_PRECISION = 5,
    parameter int ACC_WIDTH        = 64
);
    logic                                  in_valid;
    logic [CHANNELS*PIXEL_WIDTH-1:0]       pixel_word;
    logic [CHANNELS*WEIGHT_PRECISION-1:0]  weight_word;
    logic [ACC_WIDTH-1:0]                  dut_acc;
    logic                                  dut_done;
    logic                                  dut_cat_out;

    modport master (
        output in_valid, pixel_word, weight_word,
        output dut_acc, dut_done, dut_cat_out
    );

    modport slave (
        input in_valid, pixel_word, weight_word,
        input dut_acc, dut_done, dut_cat_out
    );
endinterface

// File: rtl/acc_scoreboard.sv
// acc_scoreboard: running signed MAC reference and checker for the
// recognizer accumulator. ACC_SB_FIRST_ERR_EN builds first-error capture.
module acc_scoreboard #(
    parameter int CHANNELS         = 3,
    parameter int PIXEL_WIDTH      = 8,
    parameter int WEIGHT_PRECISION = 5,
    parameter int ACC_WIDTH        = 64,
    parameter int NUM_WORDS        = 4096,
    parameter int DUT_LATENCY      = 1,
    parameter int DONE_TIMEOUT     = 64,
    parameter int ERR_CNT_WIDTH    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    acc_scoreboard_if.slave              bus,
    output logic                         busy,
    output logic [ACC_WIDTH-1:0]         exp_acc,
    output logic                         mismatch,
    output logic [ERR_CNT_WIDTH-1:0]     err_count,
    output logic                         done,
    output logic                         result_ok,
    output logic [$clog2(NUM_WORDS):0]   first_err_idx,
    output logic [ACC_WIDTH-1:0]         first_err_exp
);
    localparam int PROD_W = PIXEL_WIDTH + WEIGHT_PRECISION + 1;
    localparam int IDX_W  = $clog2(NUM_WORDS) + 1;
    localparam int TMR_W  = $clog2(DONE_TIMEOUT + 1);
    localparam int LAST   = DUT_LATENCY - 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT_DONE,
        REPORT
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     word_cnt;
    logic [TMR_W-1:0]     timer;

    logic                 pipe_v [DUT_LATENCY];
    logic [ACC_WIDTH-1:0] pipe_e [DUT_LATENCY];

    logic                 accept;
    logic [ACC_WIDTH-1:0] beat_sum;
    logic [ACC_WIDTH-1:0] acc_next;
    logic [PROD_W-1:0]    pe;
    logic [PROD_W-1:0]    we;
    logic [PROD_W-1:0]    prod;
    logic [WEIGHT_PRECISION-1:0] wbits;
    logic                 cmp_err;
    logic                 early_err;
    logic                 tmo_hit;
    logic                 cat_err;
    logic                 exp_pos;
    logic [2:0]           inc;
    logic [ERR_CNT_WIDTH:0]   err_sum;
    logic [ERR_CNT_WIDTH-1:0] err_next;

    assign busy = (state != IDLE);

    // Sum of the per-channel zext(pixel) * sext(weight) products of this word.
    always_comb begin
        beat_sum = '0;
        pe       = '0;
        we       = '0;
        prod     = '0;
        wbits    = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            wbits = bus.weight_word[c*WEIGHT_PRECISION +: WEIGHT_PRECISION];
            pe = {{(PROD_W-PIXEL_WIDTH){1'b0}},
                  bus.pixel_word[c*PIXEL_WIDTH +: PIXEL_WIDTH]};
            we = {{(PROD_W-WEIGHT_PRECISION){wbits[WEIGHT_PRECISION-1]}},
                  wbits};
            prod = pe * we;
            beat_sum = beat_sum +
                {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};
        end
    end

    // Error events of this cycle and the saturating error count they produce.
    always_comb begin
        accept    = (state == RUN) && bus.in_valid && !start;
        acc_next  = exp_acc + beat_sum;
        exp_pos   = !exp_acc[ACC_WIDTH-1] && (exp_acc != '0);
        cmp_err   = pipe_v[LAST] && (bus.dut_acc != pipe_e[LAST]);
        early_err = (state == RUN) && bus.dut_done;
        tmo_hit   = (state == WAIT_DONE) && !bus.dut_done &&
                    (timer == TMR_W'(DONE_TIMEOUT - 1));
        cat_err   = (state == WAIT_DONE) && bus.dut_done &&
                    (bus.dut_cat_out != exp_pos);
        inc       = {2'b0, cmp_err} + {2'b0, early_err} +
                    {2'b0, tmo_hit} + {2'b0, cat_err};
        err_sum   = {1'b0, err_count} + (ERR_CNT_WIDTH+1)'(inc);
        err_next  = err_sum[ERR_CNT_WIDTH] ? '1 : err_sum[ERR_CNT_WIDTH-1:0];
    end

    // Control FSM with expected accumulator, counters and verdict registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            exp_acc   <= '0;
            word_cnt  <= '0;
            timer     <= '0;
            err_count <= '0;
            mismatch  <= 1'b0;
            done      <= 1'b0;
            result_ok <= 1'b0;
        end else if (start) begin
            state     <= RUN;
            exp_acc   <= '0;
            word_cnt  <= '0;
            timer     <= '0;
            err_count <= '0;
            mismatch  <= 1'b0;
            done      <= 1'b0;
            result_ok <= 1'b0;
        end else begin
            mismatch  <= cmp_err;
            done      <= 1'b0;
            err_count <= err_next;
            unique case (state)
                IDLE: ;
                RUN: begin
                    if (accept) begin
                        exp_acc  <= acc_next;
                        word_cnt <= word_cnt + 1'b1;
                        if (word_cnt == IDX_W'(NUM_WORDS - 1)) begin
                            state <= WAIT_DONE;
                            timer <= '0;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (bus.dut_done || tmo_hit) begin
                        state <= REPORT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                REPORT: begin
                    done      <= 1'b1;
                    result_ok <= (err_next == '0);
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Compare pipeline: expected value travels DUT_LATENCY stages to meet dut_acc.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            for (int i = 0; i < DUT_LATENCY; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_e[i] <= '0;
            end
        end else begin
            pipe_v[0] <= accept;
            pipe_e[0] <= acc_next;
            for (int i = 1; i < DUT_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_e[i] <= pipe_e[i-1];
            end
        end
    end

`ifdef ACC_SB_FIRST_ERR_EN
    logic [IDX_W-1:0] pipe_i [DUT_LATENCY];
    logic             first_seen;

    // Beat index rides alongside the expected value in the compare pipeline.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            for (int i = 0; i < DUT_LATENCY; i++) begin
                pipe_i[i] <= '0;
            end
        end else begin
            pipe_i[0] <= word_cnt;
            for (int i = 1; i < DUT_LATENCY; i++) begin
                pipe_i[i] <= pipe_i[i-1];
            end
        end
    end

    // Latch index and expected value of the first accumulator mismatch.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            first_seen    <= 1'b0;
            first_err_idx <= '0;
            first_err_exp <= '0;
        end else if (cmp_err && !first_seen) begin
            first_seen    <= 1'b1;
            first_err_idx <= pipe_i[LAST];
            first_err_exp <= pipe_e[LAST];
        end
    end
`else
    assign first_err_idx = '0;
    assign first_err_exp = '0;
`endif

endmodule

// File: tb/tb_acc_scoreboard.sv
// tb_acc_scoreboard: randomized self-checking bench for acc_scoreboard
// against an integer MAC reference model and a simple fake DUT.
module tb_acc_scoreboard;
    localparam int NW  = 4;
    localparam int LAT = 2;
    localparam int TO  = 8;
    localparam int AW  = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic [AW-1:0] exp_acc;
    logic          mismatch;
    logic [15:0]   err_count;
    logic          done;
    logic          result_ok;
    logic [2:0]    first_err_idx;
    logic [AW-1:0] first_err_exp;

    acc_scoreboard_if #(
        .CHANNELS(3), .PIXEL_WIDTH(8),
        .WEIGHT_PRECISION(5), .ACC_WIDTH(AW)
    ) bus ();

    acc_scoreboard #(
        .CHANNELS(3), .PIXEL_WIDTH(8), .WEIGHT_PRECISION(5),
        .ACC_WIDTH(AW), .NUM_WORDS(NW), .DUT_LATENCY(LAT),
        .DONE_TIMEOUT(TO), .ERR_CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .busy(busy), .exp_acc(exp_acc), .mismatch(mismatch),
        .err_count(err_count), .done(done), .result_ok(result_ok),
        .first_err_idx(first_err_idx), .first_err_exp(first_err_exp)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int tk = 0;
    int mm_ticks[$];
    int done_ticks[$];
    int acc_tick[NW];
    logic [23:0] pix[NW];
    logic [14:0] wt[NW];

    logic   fd_beat = 1'b0;
    logic   fd_clr = 1'b0;
    longint fd_val = 0;
    longint dacc = 0;
    int     dcnt = 0;
    int     corrupt_idx = -1;

    longint model_acc = 0;
    int     model_err = 0;
    longint model_bad_exp = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic longint beat_val(input logic [23:0] p,
                                        input logic [14:0] w);
        longint s = 0;
        for (int c = 0; c < 3; c++)
            s += longint'(p[c*8 +: 8]) * longint'($signed(w[c*5 +: 5]));
        return s;
    endfunction

    // Fake DUT: accumulates one cycle late so dut_acc lands LAT edges after a beat.
    always @(posedge clk) begin
        if (fd_clr) begin
            dacc <= 0;
            dcnt <= 0;
        end else if (fd_beat) begin
            dacc <= dacc + fd_val;
            dcnt <= dcnt + 1;
        end
        bus.dut_acc <= (corrupt_idx >= 0 && dcnt == corrupt_idx + 1)
                       ? (dacc ^ 64'h1) : dacc;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        tk++;
        if (mismatch) mm_ticks.push_back(tk);
        if (done) done_ticks.push_back(tk);
    endtask

    task automatic begin_run();
        start = 1'b1;
        fd_clr = 1'b1;
        tick();
        start = 1'b0;
        fd_clr = 1'b0;
        model_acc = 0;
        model_err = 0;
        model_bad_exp = 0;
        mm_ticks.delete();
        done_ticks.delete();
    endtask

    task automatic send_beat(input int i, input bit gap, input bit early);
        if (gap) repeat ($urandom_range(0, 2)) tick();
        bus.in_valid = 1'b1;
        bus.pixel_word = pix[i];
        bus.weight_word = wt[i];
        bus.dut_done = early;
        fd_beat = 1'b1;
        fd_val = beat_val(pix[i], wt[i]);
        tick();
        acc_tick[i] = tk;
        model_acc += fd_val;
        if (i == corrupt_idx) begin
            model_err++;
            model_bad_exp = model_acc;
        end
        if (early) model_err++;
        bus.in_valid = 1'b0;
        bus.dut_done = 1'b0;
        fd_beat = 1'b0;
        bus.pixel_word = 24'($urandom);
        bus.weight_word = 15'($urandom);
    endtask

    task automatic send_all(input bit gap);
        for (int i = 0; i < NW; i++) send_beat(i, gap, 1'b0);
    endtask

    task automatic finish_image(input bit send_done, input bit wrong_cat,
                                input string tag);
        int  d_tick;
        int  last_tick;
        bit  want_cat;
        last_tick = tk;
        want_cat = (model_acc > 0);
        if (send_done) begin
            repeat ($urandom_range(0, 3)) tick();
            bus.dut_done = 1'b1;
            bus.dut_cat_out = want_cat ^ wrong_cat;
            tick();
            d_tick = tk;
            bus.dut_done = 1'b0;
            bus.dut_cat_out = 1'b0;
            if (wrong_cat) model_err++;
        end else begin
            model_err++;
            d_tick = last_tick + TO;
        end
        for (int n = 0; n < 40 && done_ticks.size() == 0; n++) tick();
        if (done_ticks.size() == 0) begin
            check({tag, "_done_seen"}, 0, 1);
        end else begin
            check({tag, "_done_at"}, done_ticks[0], d_tick + 1);
        end
        repeat (LAT + 1) tick();
        check({tag, "_ndone"}, done_ticks.size(), 1);
        check({tag, "_exp_acc"}, exp_acc, model_acc);
        check({tag, "_err"}, err_count, model_err);
        check({tag, "_ok"}, result_ok, model_err == 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_n_mm"}, mm_ticks.size(), corrupt_idx >= 0);
        if (corrupt_idx >= 0 && mm_ticks.size() > 0)
            check({tag, "_mm_at"}, mm_ticks[0], acc_tick[corrupt_idx] + LAT);
`ifdef ACC_SB_FIRST_ERR_EN
        check({tag, "_fidx"}, first_err_idx,
              corrupt_idx >= 0 ? corrupt_idx : 0);
        check({tag, "_fexp"}, first_err_exp, model_bad_exp);
`else
        check({tag, "_fidx"}, first_err_idx, 0);
        check({tag, "_fexp"}, first_err_exp, 0);
`endif
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_exp"}, exp_acc, 0);
        check({tag, "_err"}, err_count, 0);
        check({tag, "_mm"}, mismatch, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ok"}, result_ok, 0);
        check({tag, "_fidx"}, first_err_idx, 0);
        check({tag, "_fexp"}, first_err_exp, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.pixel_word = '0;
        bus.weight_word = '0;
        bus.dut_done = 1'b0;
        bus.dut_cat_out = 1'b0;
        repeat (3) tick();
        check_cleared("reset");
        rst = 1'b0;
        tick();

        // Matching run: 0x10 pixels, +1 weights.
        for (int i = 0; i < NW; i++) begin
            pix[i] = 24'h101010;
            wt[i] = 15'b00001_00001_00001;
        end
        begin_run();
        check("start_busy", busy, 1);
        send_all(1'b0);
        check("match_c0", model_acc, 64'hC0);
        finish_image(1'b1, 1'b0, "match");

        // Negative weights on one full beat.
        for (int i = 0; i < NW; i++) begin
            pix[i] = 24'h0;
            wt[i] = 15'($urandom);
        end
        pix[0] = 24'hFFFFFF;
        wt[0] = 15'b10000_10000_10000;
        begin_run();
        send_all(1'b1);
        check("neg_val", exp_acc, -64'sd12240);
        finish_image(1'b1, 1'b0, "neg_pass");
        begin_run();
        send_all(1'b1);
        finish_image(1'b1, 1'b1, "neg_cat");

        // Randomized matching images.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NW; i++) begin
                pix[i] = 24'($urandom);
                wt[i] = 15'($urandom);
            end
            begin_run();
            send_all(1'b1);
            finish_image(1'b1, 1'b0, "rand");
        end

        // Single corrupted accumulator at beat 2.
        corrupt_idx = 2;
        begin_run();
        send_all(1'b1);
        finish_image(1'b1, 1'b0, "corrupt");
        corrupt_idx = -1;

        // Timeout: dut_done never arrives.
        begin_run();
        send_all(1'b0);
        finish_image(1'b0, 1'b0, "timeout");

        // Restart mid-run with a simultaneous beat.
        begin_run();
        send_beat(0, 1'b0, 1'b0);
        send_beat(1, 1'b0, 1'b0);
        start = 1'b1;
        fd_clr = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        start = 1'b0;
        fd_clr = 1'b0;
        bus.in_valid = 1'b0;
        model_acc = 0;
        model_err = 0;
        model_bad_exp = 0;
        mm_ticks.delete();
        done_ticks.delete();
        check("restart_exp", exp_acc, 0);
        check("restart_busy", busy, 1);
        send_all(1'b1);
        finish_image(1'b1, 1'b0, "restart");

        // Reset mid-run, then a beat in IDLE must be ignored.
        begin_run();
        send_beat(0, 1'b0, 1'b0);
        send_beat(1, 1'b0, 1'b0);
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        check_cleared("midrst");
        bus.in_valid = 1'b1;
        bus.pixel_word = 24'h808080;
        bus.weight_word = 15'b00011_00011_00011;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("idle_beat_exp", exp_acc, 0);
        check("idle_beat_busy", busy, 0);

        // Early dut_done while still in RUN.
        for (int i = 0; i < NW; i++) begin
            pix[i] = 24'($urandom);
            wt[i] = 15'($urandom);
        end
        begin_run();
        send_beat(0, 1'b1, 1'b0);
        send_beat(1, 1'b1, 1'b1);
        check("early_err", err_count, 1);
        send_beat(2, 1'b1, 1'b0);
        send_beat(3, 1'b1, 1'b0);
        finish_image(1'b1, 1'b0, "early");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/acc_scoreboard.md
# acc_scoreboard

Synthesizable, parametrised scoreboard for the cat-recognizer accumulator datapath. It observes the same pixel/weight word stream the DUT consumes and keeps a running signed multiply-accumulate as the expected value. It compares the DUT accumulator against that value at a fixed pipeline latency and checks the final classification bit, reporting a pass/fail verdict and error count. It is instantiated beside the recognizer core in both testbench and FPGA self-test builds. It updates the expected value incrementally, one word per accepted beat, rather than recomputing the full sum every cycle.

## Interface
- CHANNELS, 3, colour channels per word
- PIXEL_WIDTH, 8, unsigned pixel width per channel
- WEIGHT_PRECISION, 5, signed two's-complement weight width per channel
- ACC_WIDTH, 64, accumulator width
- NUM_WORDS, 4096, words per image
- DUT_LATENCY, 1, cycles (≥1) from accepted beat to DUT accumulator reflecting it
- DONE_TIMEOUT, 64, max cycles to wait for dut_done after last word
- ERR_CNT_WIDTH, 16, error counter width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a new image check
- in_valid  in  1  word beat consumed by DUT this cycle
- pixel_word  in  CHANNELS*PIXEL_WIDTH  channel c at [c*PIXEL_WIDTH +: PIXEL_WIDTH]
- weight_word  in  CHANNELS*WEIGHT_PRECISION  channel c at [c*WEIGHT_PRECISION +: WEIGHT_PRECISION]
- dut_acc  in  ACC_WIDTH  DUT accumulator, signed
- dut_done  in  1  DUT result valid pulse
- dut_cat_out  in  1  DUT classification
- busy  out  1  state ≠ IDLE
- exp_acc  out  ACC_WIDTH  expected accumulator, signed
- mismatch  out  1  one-cycle pulse per failed compare
- err_count  out  ERR_CNT_WIDTH  saturating error count
- done  out  1  one-cycle verdict pulse
- result_ok  out  1  verdict; held until next start/rst
- first_err_idx  out  log2(NUM_WORDS)+1  beat index of first accumulator mismatch
- first_err_exp  out  ACC_WIDTH  expected value at first mismatch

## Operation
- Reset values: all outputs 0, state IDLE, pipeline flushed.
- States:
  - IDLE: start → RUN.
  - RUN: accept beats while in_valid; after NUM_WORDS beats → WAIT_DONE.
  - WAIT_DONE: dut_done → REPORT; timeout → REPORT with error.
  - REPORT: one cycle → IDLE.
- start in any state clears exp_acc, word counter, err_count, result_ok, the first-error registers and the compare pipeline, then enters RUN. start wins over a simultaneous in_valid; that beat is ignored.
- in_valid outside RUN is ignored.
- Per accepted beat:
  - exp_acc += Σ_c zext(pixel_c) * sext(weight_c).
  - Each product is PIXEL_WIDTH+WEIGHT_PRECISION+1 bits, signed.
  - The sum is sign-extended to ACC_WIDTH; accumulation wraps modulo 2^ACC_WIDTH.
- Compare pipeline: DUT_LATENCY stages carrying {valid, expected value, beat index}.
  - At the stage output, dut_acc ≠ expected → mismatch and err_count+1.
- Other error events, each err_count+1:
  - dut_done while in RUN (early done).
  - WAIT_DONE timeout.
  - At dut_done in WAIT_DONE, dut_cat_out ≠ (exp_acc > 0 signed).
- err_count saturates at all-ones. Errors on the same cycle add together, subject to that saturation.
- Pending pipeline compares still drain during WAIT_DONE and REPORT. A compare that retires after REPORT is still counted but does not change the verdict already issued.
- result_ok = (err_count == 0) evaluated in REPORT, including same-cycle increments.

## Timing
- start at edge N → busy=1 after N, RUN from N+1.
- Beat accepted at edge K → exp_acc updated after K.
- The compare samples dut_acc at edge K+DUT_LATENCY; mismatch is high for the cycle after that edge.
- The last beat moves the state to WAIT_DONE at the same edge.
- dut_done at edge D → REPORT after D; done=1 and result_ok valid after D+1.
- Timeout: WAIT_DONE lasts DONE_TIMEOUT cycles without dut_done, then REPORT.
- rst mid-operation behaves exactly as the reset values above and takes precedence over start.

## Configuration
- ACC_SB_FIRST_ERR_EN defined:
  - first_err_idx and first_err_exp latch on the first accumulator mismatch after start.
  - They hold until the next start or rst.
- ACC_SB_FIRST_ERR_EN undefined:
  - Capture registers are not built; both outputs are tied to 0.
  - All other behaviour is identical.

## Test plan
- Matching run: NUM_WORDS=4, all pixels 0x10, all weights +1, DUT matches, dut_cat_out=1 → exp_acc=0xC0, err_count=0, result_ok=1, one done pulse.
- Negative weights: weights 5'b10000 (−16), pixel 0xFF, one beat with all 3 channels → exp_acc = −12240. dut_cat_out=0 → pass; dut_cat_out=1 → err_count=1, result_ok=0.
- Single mismatch: DUT_LATENCY=2, corrupt dut_acc at beat 2 → mismatch one cycle after edge K+2, err_count=1. With the macro: first_err_idx=2 and first_err_exp equals that beat's expected value.
- Timeout: no dut_done after the last beat, DONE_TIMEOUT=8 → REPORT after 8 cycles, err_count=1, result_ok=0.
- Restart: start asserted together with in_valid mid-RUN → counters and pipeline cleared, that beat ignored, next run passes.
- Reset and early done: rst mid-RUN → all outputs 0, IDLE. dut_done while in RUN → err_count increments by 1.
